// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
//
// Shared definitions for the mesh network-interface blocks.
//   - Flit geometry: FLIT_W, PAYLOAD_W, ID_W and the bit position of each field.
//   - flit_t: packed flit layout {dest_cluster, dest_local, payload}.
//   - make_flit(): builds a flit from its fields.
//   - Router port indices; the node-local port is 5 (in5/vi5/co5).
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_W    = 20;
  localparam int PAYLOAD_W = 16;
  localparam int ID_W      = 2;

  // Field bit positions inside a flit.
  localparam int PAYLOAD_LSB      = 0;
  localparam int PAYLOAD_MSB      = PAYLOAD_LSB + PAYLOAD_W - 1;  // 15
  localparam int DEST_LOCAL_LSB   = PAYLOAD_MSB + 1;              // 16
  localparam int DEST_LOCAL_MSB   = DEST_LOCAL_LSB + ID_W - 1;    // 17
  localparam int DEST_CLUSTER_LSB = DEST_LOCAL_MSB + 1;           // 18
  localparam int DEST_CLUSTER_MSB = DEST_CLUSTER_LSB + ID_W - 1;  // 19

  // Packed so that dest_cluster lands in [19:18], dest_local in [17:16],
  // payload in [15:0].
  typedef struct packed {
    logic [ID_W-1:0]      dest_cluster;
    logic [ID_W-1:0]      dest_local;
    logic [PAYLOAD_W-1:0] payload;
  } flit_t;

  // Router port indices.
  localparam int NUM_PORTS     = 6;
  localparam int PORT_NORTH    = 0;
  localparam int PORT_EAST     = 1;
  localparam int PORT_SOUTH    = 2;
  localparam int PORT_WEST     = 3;
  localparam int PORT_CLUSTER  = 4;
  localparam int PORT_LOCAL    = 5;

  function automatic flit_t make_flit(input logic [ID_W-1:0]      dest_cluster,
                                      input logic [ID_W-1:0]      dest_local,
                                      input logic [PAYLOAD_W-1:0] payload);
    flit_t f;
    f.dest_cluster = dest_cluster;
    f.dest_local   = dest_local;
    f.payload      = payload;
    return f;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// -----------------------------------------------------------------------------
// noc_sync_fifo
//
// Single-clock FIFO with a combinational head (first-word fall-through).
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset (empties the FIFO)
//   push       in   write push_data; ignored when full
//   push_data  in   WIDTH-bit write data
//   pop        in   drop the head entry; ignored when empty
//   pop_data   out  current head entry (valid while !empty)
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
//   count      out  number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module noc_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             do_push;
  logic             do_pop;

  assign full     = (occ == DEPTH_C);
  assign empty    = (occ == '0);
  assign count    = occ;
  assign pop_data = mem[rd_ptr];

  // Guards make an overflowing push or an underflowing pop a no-op.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/noc_injector.sv
// -----------------------------------------------------------------------------
// noc_injector
//
// Injection-side network interface. Buffers payload requests as flits and
// launches them into router local input port 5 under credit flow control.
//
// Optional feature macro: NOC_INJ_SELF_DROP_EN
//   defined   : requests addressed to this node are accepted and discarded.
//   undefined : self-addressed requests are injected like any other.
//
// Handshakes:
//   Request side is valid/ready: a request transfers on a rising edge where
//   req_valid && req_ready. req_ready depends only on FIFO occupancy, so a
//   pop in the same cycle never opens a slot early. Router side has no ready:
//   out_valid is a one-cycle pulse per flit, permitted only while credits > 0;
//   the router returns each freed buffer slot as a one-cycle ci pulse.
//
// Ports:
//   clk               in   clock, rising edge
//   rst               in   asynchronous active-low reset
//   my_cluster        in   this node's cluster id (quasi-static)
//   my_local          in   this node's local id (quasi-static)
//   req_valid         in   request present
//   req_ready         out  FIFO has room
//   req_dest_cluster  in   destination cluster
//   req_dest_local    in   destination local id
//   req_data          in   16-bit payload
//   dataout           out  registered flit to router in5
//   out_valid         out  dataout carries a new flit this cycle (vi5)
//   ci                in   credit return pulse from router co5
//   tx_count          out  flits launched, wraps at 2^16
//   credit_err        out  sticky: credit returned while already full
// -----------------------------------------------------------------------------
module noc_injector
  import noc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_W-1:0]       my_cluster,
  input  logic [ID_W-1:0]       my_local,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_W-1:0]       req_dest_cluster,
  input  logic [ID_W-1:0]       req_dest_local,
  input  logic [PAYLOAD_W-1:0]  req_data,
  output logic [FLIT_W-1:0]     dataout,
  output logic                  out_valid,
  input  logic                  ci,
  output logic [15:0]           tx_count,
  output logic                  credit_err
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(BUF_DEPTH);

  // ---------------------------------------------------------------------------
  // Request buffer
  // ---------------------------------------------------------------------------
  flit_t                       push_flit;
  flit_t                       head_flit;
  logic [FLIT_W-1:0]           head_bits;
  logic                        fifo_push;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        accept;
  logic                        is_self;
  logic                        launch;

  logic [CW-1:0]               credits;

  assign push_flit = make_flit(req_dest_cluster, req_dest_local, req_data);
  assign is_self   = (req_dest_cluster == my_cluster) && (req_dest_local == my_local);

  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;

`ifdef NOC_INJ_SELF_DROP_EN
  // A self-addressed request completes its handshake but never enters the
  // buffer, so it costs no credit and never shows up in tx_count.
  assign fifo_push = accept && !is_self;
  logic unused_ok;
  assign unused_ok = ^fifo_count;
`else
  assign fifo_push = accept;
  logic unused_ok;
  assign unused_ok = ^{fifo_count, is_self};
`endif

  noc_sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_flit),
    .pop       (launch),
    .pop_data  (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_flit = flit_t'(head_bits);

  // A flit leaves whenever one is buffered and the router has a free slot.
  // Credits returned this edge are only counted from the next edge on.
  assign launch = !fifo_empty && (credits != '0);

  // ---------------------------------------------------------------------------
  // Credit counter and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits    <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      case ({ci, launch})
        2'b10: begin
          // A return beyond the router's buffer depth means the two sides
          // disagree; hold saturation and flag it until reset.
          if (credits == CRED_MAX) begin
            credit_err <= 1'b1;
          end else begin
            credits <= credits + 1'b1;
          end
        end
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;  // idle, or return and spend cancel
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and launch counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataout   <= '0;
      out_valid <= 1'b0;
      tx_count  <= '0;
    end else begin
      out_valid <= launch;
      if (launch) begin
        // dataout keeps the previous flit between launches.
        dataout  <= head_flit;
        tx_count <= tx_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_noc_injector.sv
module tb_noc_injector;

  logic        clk;
  logic        rst;
  logic [1:0]  my_cluster;
  logic [1:0]  my_local;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_dest_cluster;
  logic [1:0]  req_dest_local;
  logic [15:0] req_data;
  logic [19:0] dataout;
  logic        out_valid;
  logic        ci;
  logic [15:0] tx_count;
  logic        credit_err;

  int checks = 0;
  int errors = 0;
  int flit_cnt = 0;
  int cyc = 0;
  int vcyc[$];
  logic [19:0] exp_q[$];

  bit drop_en;

  noc_injector #(.FIFO_DEPTH(4), .BUF_DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .my_cluster       (my_cluster),
    .my_local         (my_local),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_dest_cluster (req_dest_cluster),
    .req_dest_local   (req_dest_local),
    .req_data         (req_data),
    .dataout          (dataout),
    .out_valid        (out_valid),
    .ci               (ci),
    .tx_count         (tx_count),
    .credit_err       (credit_err)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst && out_valid) begin
      logic [19:0] e;
      flit_cnt++;
      vcyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_flit actual=%05h required=none", dataout);
      end else begin
        e = exp_q.pop_front();
        if (dataout !== e) begin
          errors++;
          $display("FAIL flit_data actual=%05h required=%05h", dataout, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers (called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ci_cycles(input int n);
    ci = 1'b1;
    repeat (n) @(posedge clk);
    #1 ci = 1'b0;
  endtask

  task automatic send(input logic [1:0] dc, input logic [1:0] dl,
                      input logic [15:0] d, input bit expect_flit);
    bit ok;
    req_dest_cluster = dc;
    req_dest_local   = dl;
    req_data         = d;
    req_valid        = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout actual=not_ready required=ready");
      @(posedge clk);
      #1 req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (expect_flit) exp_q.push_back({dc, dl, d});
    #1 req_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int base;
    int m;
`ifdef NOC_INJ_SELF_DROP_EN
    drop_en = 1'b1;
`else
    drop_en = 1'b0;
`endif
    rst = 1'b0;
    my_cluster = 2'd2;
    my_local = 2'd3;
    req_valid = 1'b0;
    req_dest_cluster = '0;
    req_dest_local = '0;
    req_data = '0;
    ci = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dataout", 32'(dataout), 32'd0);
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_credit_err", 32'(credit_err), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    wait_cycles(1);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // T1: single request, 2-cycle latency
    send(2'd1, 2'd2, 16'hBEEF, 1'b1);
    @(negedge clk);
    chk("t1_lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(dataout), 32'h6BEEF);
    @(negedge clk);
    chk("t1_pulse", 32'(out_valid), 32'd0);
    chk("t1_tx_count", 32'(tx_count), 32'd1);
    @(posedge clk);
    #1;
    // Credits were 3: one return brings them to 4 without an error.
    ci_cycles(1);
    wait_cycles(2);
    chk("t1_credits_3", 32'(credit_err), 32'd0);

    // T2: five back-to-back, four credits
    vcyc.delete();
    send(2'd0, 2'd1, 16'hA001, 1'b1);
    send(2'd3, 2'd0, 16'hA002, 1'b1);
    send(2'd1, 2'd1, 16'hA003, 1'b1);
    send(2'd2, 2'd2, 16'hA004, 1'b1);
    send(2'd0, 2'd3, 16'hA005, 1'b1);
    wait_cycles(6);
    chk("t2_flits", 32'(vcyc.size()), 32'd4);
    if (vcyc.size() >= 4) chk("t2_consecutive", 32'(vcyc[3] - vcyc[0]), 32'd3);
    chk("t2_held", 32'(exp_q.size()), 32'd1);
    chk("t2_tx_count", 32'(tx_count), 32'd5);
    ci_cycles(1);
    m = cyc;
    wait_cycles(3);
    chk("t2_flits_after_ci", 32'(vcyc.size()), 32'd5);
    if (vcyc.size() >= 5) chk("t2_ci_latency", 32'(vcyc[4]), 32'(m + 1));
    chk("t2_tx_count2", 32'(tx_count), 32'd6);

    // T3: zero credits, FIFO_DEPTH+1 requests
    base = flit_cnt;
    send(2'd1, 2'd0, 16'hC001, 1'b1);
    send(2'd1, 2'd1, 16'hC002, 1'b1);
    send(2'd1, 2'd2, 16'hC003, 1'b1);
    send(2'd1, 2'd3, 16'hC004, 1'b1);
    chk("t3_full", 32'(req_ready), 32'd0);
    fork
      send(2'd3, 2'd3, 16'hC005, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t3_ready_low", 32'(req_ready), 32'd0);
        end
        chk("t3_no_flits", 32'(flit_cnt - base), 32'd0);
        ci_cycles(1);
      end
    join
    ci_cycles(4);
    wait_cycles(8);
    chk("t3_flits", 32'(flit_cnt - base), 32'd5);
    chk("t3_tx_count", 32'(tx_count), 32'd11);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // T4: simultaneous launch and credit return, then overflow
    base = flit_cnt;
    send(2'd2, 2'd0, 16'hD001, 1'b1);
    ci_cycles(2);
    wait_cycles(2);
    chk("t4_first", 32'(flit_cnt - base), 32'd1);
    send(2'd0, 2'd2, 16'hD002, 1'b1);
    wait_cycles(3);
    chk("t4_credit_unchanged", 32'(flit_cnt - base), 32'd2);
    chk("t4_tx_count", 32'(tx_count), 32'd13);
    ci_cycles(4);
    wait_cycles(2);
    chk("t4_no_err_at_full", 32'(credit_err), 32'd0);
    ci_cycles(1);
    @(negedge clk);
    chk("t4_err_rise", 32'(credit_err), 32'd1);
    @(posedge clk);
    #1;
    wait_cycles(5);
    chk("t4_err_sticky", 32'(credit_err), 32'd1);

    // T5: reset mid-operation with 3 flits buffered, 0 credits
    base = flit_cnt;
    send(2'd3, 2'd1, 16'hE001, 1'b1);
    send(2'd3, 2'd2, 16'hE002, 1'b1);
    send(2'd3, 2'd0, 16'hE003, 1'b1);
    send(2'd2, 2'd1, 16'hE004, 1'b1);
    wait_cycles(3);
    send(2'd1, 2'd3, 16'hE005, 1'b1);
    send(2'd0, 2'd0, 16'hE006, 1'b1);
    send(2'd1, 2'd0, 16'hE007, 1'b1);
    wait_cycles(2);
    chk("t5_pre_flits", 32'(flit_cnt - base), 32'd4);
    chk("t5_pre_tx", 32'(tx_count), 32'd17);
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", 32'(dataout), 32'd0);
    chk("t5_rst_tx", 32'(tx_count), 32'd0);
    chk("t5_rst_err", 32'(credit_err), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    base = flit_cnt;
    wait_cycles(10);
    chk("t5_nothing", 32'(flit_cnt - base), 32'd0);
    send(2'd0, 2'd1, 16'hF001, 1'b1);
    send(2'd1, 2'd2, 16'hF002, 1'b1);
    send(2'd2, 2'd0, 16'hF003, 1'b1);
    send(2'd3, 2'd3, 16'hF004, 1'b1);
    send(2'd0, 2'd0, 16'hF005, 1'b1);
    wait_cycles(6);
    chk("t5_credits_4", 32'(flit_cnt - base), 32'd4);
    chk("t5_held", 32'(exp_q.size()), 32'd1);
    ci_cycles(1);
    wait_cycles(3);
    chk("t5_last", 32'(flit_cnt - base), 32'd5);
    chk("t5_tx", 32'(tx_count), 32'd5);

    // T6: self-addressed request, my id (2,3)
    ci_cycles(1);
    base = flit_cnt;
    send(2'd2, 2'd3, 16'h1234, !drop_en);
    wait_cycles(5);
    chk("t6_ready", 32'(req_ready), 32'd1);
    if (drop_en) begin
      chk("t6_drop_flits", 32'(flit_cnt - base), 32'd0);
      chk("t6_drop_tx", 32'(tx_count), 32'd5);
    end else begin
      chk("t6_self_flits", 32'(flit_cnt - base), 32'd1);
      chk("t6_self_tx", 32'(tx_count), 32'd6);
      chk("t6_self_data", 32'(dataout), 32'hB1234);
    end

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
